// File: rtl/ldl_ram_p1_pkg.sv
// rtl/ldl_ram_p1_pkg.sv - shared types and constants for the 1-port RAM master
package ldl_ram_p1_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

    localparam int RSP_DEPTH = 2;
    localparam int STAT_W    = 32;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

endpackage

// File: rtl/ldl_ram_p1_rsp_fifo.sv
// rtl/ldl_ram_p1_rsp_fifo.sv - 2-entry in-order valid/ready response buffer
module ldl_ram_p1_rsp_fifo
    import ldl_ram_p1_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push_valid,
    input  logic [DWIDTH-1:0] i_push_data,
    input  logic              i_pop_ready,
    output logic              o_pop_valid,
    output logic [DWIDTH-1:0] o_pop_data,
    output logic [CNT_W-1:0]  o_count
);

    logic [DWIDTH-1:0] r_mem [RSP_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_pop;
    logic              w_full;

    assign o_pop_valid = (r_cnt != '0);
    assign o_pop_data  = r_mem[r_rd_ptr];
    assign o_count     = r_cnt;
    assign w_pop       = o_pop_valid & i_pop_ready;
    assign w_full      = (r_cnt == CNT_W'(RSP_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (i_push_valid) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push_valid, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // The master's read credit must make a push into a full, non-draining buffer impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push_valid && !w_pop && w_full));
        end
    end

endmodule

// File: rtl/ldl_ram_p1_master.sv
// rtl/ldl_ram_p1_master.sv - write/read arbiter driving a 1-port RAM; optional LDL_RAM_P1_MASTER_STAT_EN counters
module ldl_ram_p1_master
    import ldl_ram_p1_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              ram_re,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout
`ifdef LDL_RAM_P1_MASTER_STAT_EN
    ,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_rd_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

    logic             r_inflight;
    logic             r_last_wr;
    grant_e           w_grant;
    logic [CNT_W-1:0] w_cnt;
    logic             w_pop;
    logic [2:0]       w_credit;
    logic             w_rd_ok;

    assign w_pop    = rsp_valid & rsp_ready;
    assign w_credit = {1'b0, w_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_ok  = (w_credit < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_last_wr  <= 1'b1;
        end else begin
            r_inflight <= (w_grant == GNT_RD);
            if (w_grant != GNT_NONE) begin
                r_last_wr <= (w_grant == GNT_WR);
            end
        end
    end

    // Round-robin only applies when a read can be taken; writes never need credit.
    always_comb begin
        w_grant = GNT_NONE;
        if (!rst) begin
            if (wr_valid && rd_valid && w_rd_ok) begin
                w_grant = r_last_wr ? GNT_RD : GNT_WR;
            end else if (wr_valid) begin
                w_grant = GNT_WR;
            end else if (rd_valid && w_rd_ok) begin
                w_grant = GNT_RD;
            end
        end
    end

    always_comb begin
        wr_ready = (w_grant == GNT_WR);
        rd_ready = (w_grant == GNT_RD);
        ram_we   = (w_grant == GNT_WR);
        ram_re   = (w_grant == GNT_RD);
        ram_addr = (w_grant == GNT_WR) ? wr_addr : rd_addr;
        ram_din  = wr_data;
    end

    ldl_ram_p1_rsp_fifo #(
        .DWIDTH (DWIDTH)
    ) u_rsp_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (r_inflight),
        .i_push_data  (ram_dout),
        .i_pop_ready  (rsp_ready),
        .o_pop_valid  (rsp_valid),
        .o_pop_data   (rsp_data),
        .o_count      (w_cnt)
    );

`ifdef LDL_RAM_P1_MASTER_STAT_EN
    logic [STAT_W-1:0] r_stat_wr;
    logic [STAT_W-1:0] r_stat_rd;
    logic [STAT_W-1:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_wr    <= '0;
            r_stat_rd    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (wr_ready) r_stat_wr <= r_stat_wr + STAT_W'(1);
            if (rd_ready) r_stat_rd <= r_stat_rd + STAT_W'(1);
            if (rd_valid && !rd_ready) r_stat_stall <= r_stat_stall + STAT_W'(1);
        end
    end

    assign stat_wr_cnt    = r_stat_wr;
    assign stat_rd_cnt    = r_stat_rd;
    assign stat_stall_cnt = r_stat_stall;
`endif

endmodule

// File: tb/tb_ldl_ram_p1_master.sv
// tb/tb_ldl_ram_p1_master.sv - scoreboard bench for ldl_ram_p1_master
module tb_ldl_ram_p1_master;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr, ram_addr;
    logic [DW-1:0] wr_data, rsp_data, ram_din, ram_dout;
    logic          rsp_valid, rsp_ready, ram_re, ram_we;
`ifdef LDL_RAM_P1_MASTER_STAT_EN
    logic [31:0]   stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    ldl_ram_p1_master #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef LDL_RAM_P1_MASTER_STAT_EN
        ,
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] exp_mem [16];
    logic [DW-1:0] sb [$];
    int n_cmp = 0;
    int n_err = 0;
    int n_wr = 0, n_rd = 0, n_pop = 0, n_both = 0;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= ram_mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (ram_re && ram_we) n_both++;
            if (wr_valid && wr_ready) begin
                exp_mem[wr_addr] = wr_data;
                n_wr++;
            end
            if (rd_valid && rd_ready) begin
                sb.push_back(exp_mem[rd_addr]);
                n_rd++;
            end
            if (rsp_valid && rsp_ready) begin
                n_pop++;
                if (sb.size() == 0) check_val("rsp_unexpected", 32'd1, 32'd0);
                else check_val("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 20; k++) begin
            tick();
            if (sb.size() == 0 && !rsp_valid) break;
        end
        check_val(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, p0, idx;
        logic [AW-1:0] t4_addr [3];
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = '0;
            exp_mem[i] = '0;
        end
        t4_addr[0] = 4'd1; t4_addr[1] = 4'd2; t4_addr[2] = 4'd3;
        rst = 1'b1;
        wr_valid = 1'b1; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b1; rd_addr = '0; rsp_ready = 1'b0;

        tick(); tick();
        smp();
        check_val("rst_rdy", {30'd0, wr_ready, rd_ready}, 32'd0);
        check_val("rst_ram", {30'd0, ram_we, ram_re}, 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;

        // Contended: first grant must go to read, then alternate
        wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 8'h5A;
        rd_valid = 1'b1; rd_addr = 4'd2; rsp_ready = 1'b1;
        w0 = n_wr; r0 = n_rd;
        for (int i = 0; i < 8; i++) begin
            smp();
            check_val($sformatf("rr_gnt%0d", i), {30'd0, wr_ready, rd_ready},
                      (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        drain("rr_drain");
        check_val("rr_wr_cnt", 32'(n_wr - w0), 32'd4);
        check_val("rr_rd_cnt", 32'(n_rd - r0), 32'd4);
        check_val("rr_both", 32'(n_both), 32'd0);

        // Write then read, latency check
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        smp();
        check_val("lat_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd3;
        smp();
        check_val("lat_rd_ready", 32'(rd_ready), 32'd1);
        tick();
        rd_valid = 1'b0;
        smp();
        check_val("lat_t1_valid", 32'(rsp_valid), 32'd0);
        tick();
        smp();
        check_val("lat_t2_valid", 32'(rsp_valid), 32'd1);
        check_val("lat_t2_data", 32'(rsp_data), 32'hA5);
        tick();

        // Preload 0..7 and stream reads back
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = DW'(8'h10 + i);
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_valid = (i < 8);
            rd_addr  = AW'(i % 8);
            smp();
            if (i < 8) check_val($sformatf("bb_rd_ready%0d", i), 32'(rd_ready), 32'd1);
            if (i >= 2) begin
                check_val($sformatf("bb_valid%0d", i), 32'(rsp_valid), 32'd1);
                check_val($sformatf("bb_data%0d", i), 32'(rsp_data), 32'(8'h10 + i - 2));
            end
            tick();
        end
        rd_valid = 1'b0;
        drain("bb_drain");

        // Backpressure: credit stops at two outstanding reads
        rsp_ready = 1'b0; idx = 0; p0 = n_pop;
        for (int c = 0; c < 6; c++) begin
            rd_valid = (idx < 3);
            rd_addr  = t4_addr[idx % 3];
            smp();
            if (rd_valid && rd_ready) idx++;
            tick();
        end
        smp();
        check_val("bp_accepts", 32'(idx), 32'd2);
        check_val("bp_rd_ready", 32'(rd_ready), 32'd0);
        check_val("bp_head_valid", 32'(rsp_valid), 32'd1);
        check_val("bp_head_data", 32'(rsp_data), 32'h11);
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rd_valid = (idx < 3);
            rd_addr  = t4_addr[idx % 3];
            smp();
            if (rd_valid && rd_ready) idx++;
            tick();
        end
        rd_valid = 1'b0;
        drain("bp_drain");
        check_val("bp_accepts_total", 32'(idx), 32'd3);
        check_val("bp_pops", 32'(n_pop - p0), 32'd3);

        // Reset with one response buffered and one read in flight
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 4'd1;
        smp();
        check_val("mr_rd1", 32'(rd_ready), 32'd1);
        tick();
        rd_addr = 4'd2;
        smp();
        check_val("mr_rd2", 32'(rd_ready), 32'd1);
        tick();
        rd_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        check_val("mr_valid_after", 32'(rsp_valid), 32'd0);
        tick();
        rsp_ready = 1'b1;
        p0 = n_pop;
        for (int c = 0; c < 3; c++) begin
            smp();
            check_val($sformatf("mr_stale%0d", c), 32'(rsp_valid), 32'd0);
            tick();
        end
        check_val("mr_no_pops", 32'(n_pop - p0), 32'd0);
        rd_valid = 1'b1; rd_addr = 4'd5;
        tick();
        rd_valid = 1'b0;
        tick();
        smp();
        check_val("mr_new_valid", 32'(rsp_valid), 32'd1);
        check_val("mr_new_data", 32'(rsp_data), 32'h15);
        drain("mr_drain");

`ifdef LDL_RAM_P1_MASTER_STAT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        check_val("st_zero_wr", stat_wr_cnt, 32'd0);
        check_val("st_zero_rd", stat_rd_cnt, 32'd0);
        check_val("st_zero_stall", stat_stall_cnt, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(10 + i); wr_data = DW'(8'h60 + i);
            tick();
        end
        wr_valid = 1'b0;
        rsp_ready = 1'b0; idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) rsp_ready = 1'b1;
            rd_valid = (idx < 5);
            rd_addr  = AW'(idx);
            smp();
            if (rd_valid && rd_ready) idx++;
            tick();
        end
        rd_valid = 1'b0;
        drain("st_drain");
        check_val("st_wr", stat_wr_cnt, 32'd3);
        check_val("st_rd", stat_rd_cnt, 32'd5);
        check_val("st_stall", stat_stall_cnt, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        check_val("st_rst_wr", stat_wr_cnt, 32'd0);
        check_val("st_rst_rd", stat_rd_cnt, 32'd0);
        check_val("st_rst_stall", stat_stall_cnt, 32'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
